sample_fifo: RTL and testbench
==============================

# sample_fifo

Parametrised synchronous FIFO for the audio sample path, the next generation of the fixed 12-bit sample FIFO. It adds width/depth parameters, a fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a non-destructive peek port. The peek port reads any stored sample at an offset from the head, which lets the pitch-shifter read the buffer like a delay line without dequeuing.

## Interface
- WIDTH, 12: sample width in bits.
- DEPTH, 2048: number of entries; must be a power of two and at least 4.
- AF_MARGIN, 2: almost_full asserts when count >= DEPTH-AF_MARGIN.
- AE_MARGIN, 2: almost_empty asserts when count <= AE_MARGIN.
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enqueue  in  1  write request for data_in.
- dequeue  in  1  read request from the head.
- data_in  in  WIDTH  sample to write.
- flush  in  1  synchronous empty; has priority over enqueue and dequeue.
- clear_flags  in  1  clears overflow and underflow.
- peek_req  in  1  non-destructive read request.
- peek_offset  in  $clog2(DEPTH)  offset from head; 0 is the oldest entry.
- data_out  out  WIDTH  dequeued sample, registered.
- data_valid  out  1  one-cycle strobe qualifying data_out.
- peek_data  out  WIDTH  peeked sample, registered.
- peek_valid  out  1  one-cycle strobe; peek_data is valid.
- peek_err  out  1  one-cycle strobe; the peek offset was out of range.
- full, empty  out  1 each  count==DEPTH and count==0 respectively.
- almost_full, almost_empty  out  1 each  threshold flags.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Storage: DEPTH x WIDTH array with read and write pointers of $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH.
- Writes are accepted when enqueue && (!full || dequeue).
  - At full with dequeue also high, both the write and the read occur and count is unchanged.
  - enqueue at full without dequeue drops the sample and sets overflow.
- Reads are accepted when dequeue && !empty. data_out takes mem[rd_ptr] and data_valid pulses.
  - dequeue at empty sets underflow. There is no fall-through: a simultaneous enqueue at empty is written and the read is ignored.
- count is incremented on write-only, decremented on read-only, and held otherwise.
- flush: pointers and count go to 0. The enqueue/dequeue in the same cycle is ignored. data_valid is 0 that cycle. Sticky flags are not cleared.
- Peek, sampled using pre-edge state:
  - If peek_offset < count: peek_data = mem[(rd_ptr+peek_offset) mod DEPTH] and peek_valid=1.
  - Otherwise: peek_err=1 and peek_data is held.
  - A peek concurrent with a dequeue reads using the pre-dequeue head.
- Sticky flags: set by the error conditions above and cleared by clear_flags. Set wins over clear when both occur in the same cycle.
- Memory contents are not reset; only pointers, count and outputs are.

## Timing
- Reset values: data_out=0, data_valid=0, peek_data=0, peek_valid=0, peek_err=0, full=0, empty=1, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0.
- Reset is asynchronous: outputs take their reset values immediately on reset assertion, including mid-operation. The first accepted operation is at the first rising edge after reset deasserts.
- Dequeue latency: data_out/data_valid are valid in the cycle after the edge that accepts dequeue. There is one strobe per accepted read, and back-to-back reads give one sample per cycle.
- Peek latency: 1 cycle, independent of dequeue.
- full, empty, almost_*, and count are registered and reflect the state after each edge. A sample written at edge N is readable by a dequeue sampled at edge N+1.
- Throughput: one enqueue plus one dequeue per cycle, sustained.

## Test plan
- Fill, with WIDTH=12, DEPTH=16, AF/AE_MARGIN=2: after reset, enqueue 0..15 on consecutive cycles.
  - Response: almost_empty drops once count=3, almost_full rises at count=14, full=1 and count=16 after the 16th write, with no overflow.
- Overflow: while full, enqueue 999 without dequeue.
  - Response: overflow=1 and count=16.
  - Then dequeue 16 times: data_out is 0..15 with data_valid each cycle, and empty=1 at the end.
- Simultaneous operations:
  - At full, enqueue 500 with dequeue: count stays 16, data_out=0, and 500 appears 16 reads later.
  - At empty, enqueue 7 with dequeue: underflow=1, no data_valid, count=1.
- Peek: write 100..109.
  - peek_offset=3: peek_data=103 and peek_valid one cycle later.
  - peek_offset=10: peek_err=1.
  - Peek 0 concurrent with a dequeue: both return 100.
- Wrap-around: stream 0..39 with dequeue enabled from the 9th write onward.
  - Response: outputs 0..39 in order across pointer wrap, and count never exceeds 9.
- Flush/reset: at count=5, flush with enqueue.
  - Response: count=0, empty=1, sticky flags kept.
  - Then clear_flags clears them. Asserting reset mid-stream forces all outputs to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sample_fifo.sv
// sample_fifo
//   Parametrised synchronous FIFO for the audio sample path. It provides
//   registered dequeue data, a fill count, almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags, a synchronous flush and a
//   non-destructive peek port that reads any stored entry at an offset from
//   the head. The peek port lets the pitch-shifter use the buffer as a delay
//   line.
//
//   Parameters
//     WIDTH      sample width in bits
//     DEPTH      entry count; must be a power of two and at least 4
//     AF_MARGIN  almost_full  when count >= DEPTH-AF_MARGIN
//     AE_MARGIN  almost_empty when count <= AE_MARGIN
//
//   Ports
//     clock, reset              rising-edge clock, async active-high reset
//     enqueue, data_in          write request and sample
//     dequeue                   read request from the head
//     flush                     synchronous empty; beats enqueue/dequeue
//     clear_flags               clears overflow/underflow (set wins)
//     peek_req, peek_offset     non-destructive read at head+offset
//     data_out, data_valid      registered dequeue data + 1-cycle strobe
//     peek_data, peek_valid     registered peek data + 1-cycle strobe
//     peek_err                  1-cycle strobe: offset >= count
//     full, empty               count==DEPTH / count==0
//     almost_full, almost_empty threshold flags
//     count                     occupancy 0..DEPTH
//     overflow, underflow       sticky error flags
module sample_fifo #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 2048,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enqueue,
    input  logic                     dequeue,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     flush,
    input  logic                     clear_flags,
    input  logic                     peek_req,
    input  logic [$clog2(DEPTH)-1:0] peek_offset,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic [WIDTH-1:0]         peek_data,
    output logic                     peek_valid,
    output logic                     peek_err,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_TH   = CW'(AE_MARGIN);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // Storage is deliberately not reset so it can map onto RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          wr_ok;
    logic          rd_ok;
    logic          ovf_set;
    logic          unf_set;
    logic [CW-1:0] count_nxt;
    logic          peek_hit;
    logic [AW-1:0] peek_addr;

    // ------------------------------------------------------------------
    // Accept logic. A write at full is only legal when the same edge also
    // frees a slot, so the read must be accepted too (full implies !empty).
    // Flush suppresses every request, including the error side effects.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ok     = !flush && enqueue && (!full || dequeue);
        rd_ok     = !flush && dequeue && !empty;
        ovf_set   = !flush && enqueue && full && !dequeue;
        unf_set   = !flush && dequeue && empty;

        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (wr_ok && !rd_ok)
            count_nxt = count + ONE_C;
        else if (rd_ok && !wr_ok)
            count_nxt = count - ONE_C;

        // Peek uses the pre-edge head and count, so a concurrent dequeue
        // does not shift the window seen by this peek.
        peek_hit  = {1'b0, peek_offset} < count;
        peek_addr = rd_ptr + peek_offset;
    end

    // ------------------------------------------------------------------
    // Memory write. At full with a concurrent dequeue wr_ptr==rd_ptr; the
    // read below samples the old word because both use the pre-edge value.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[wr_ptr] <= data_in;
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and status flags. Flags are computed from the
    // next count so they reflect the state after each edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (wr_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_TH);
            almost_empty <= (count_nxt <= AE_TH);
        end
    end

    // ------------------------------------------------------------------
    // Dequeue output: data_out holds its last value between strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (rd_ok)
                data_out <= mem[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Peek output: an out-of-range offset strobes peek_err and leaves
    // peek_data untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peek_data  <= '0;
            peek_valid <= 1'b0;
            peek_err   <= 1'b0;
        end else begin
            peek_valid <= peek_req && peek_hit;
            peek_err   <= peek_req && !peek_hit;
            if (peek_req && peek_hit)
                peek_data <= mem[peek_addr];
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a new error in the same cycle as clear_flags
    // keeps the flag set.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set || (overflow  && !clear_flags);
            underflow <= unf_set || (underflow && !clear_flags);
        end
    end

endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo
//   Directed plus randomized bench for sample_fifo (WIDTH=12, DEPTH=16).
//   A queue-based reference model predicts every output after each edge.
module tb_sample_fifo;

    localparam int WIDTH = 12;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset;
    logic             enqueue, dequeue, flush, clear_flags, peek_req;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    peek_offset;
    logic [WIDTH-1:0] data_out, peek_data;
    logic             data_valid, peek_valid, peek_err;
    logic             full, empty, almost_full, almost_empty;
    logic [AW:0]      count;
    logic             overflow, underflow;

    sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
        .clock(clock), .reset(reset), .enqueue(enqueue), .dequeue(dequeue),
        .data_in(data_in), .flush(flush), .clear_flags(clear_flags),
        .peek_req(peek_req), .peek_offset(peek_offset),
        .data_out(data_out), .data_valid(data_valid),
        .peek_data(peek_data), .peek_valid(peek_valid), .peek_err(peek_err),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model state
    int             q[$];
    bit             m_ov, m_un, m_dv, m_pv, m_pe;
    logic [WIDTH-1:0] m_dout, m_pd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_un = 0; m_dv = 0; m_pv = 0; m_pe = 0;
        m_dout = '0; m_pd = '0;
    endtask

    task automatic model_update(input bit enq, input bit deq, input int din,
                                input bit fl, input bit clr, input bit pk, input int off);
        int sz;
        bit ovs, uns;
        sz  = q.size();
        ovs = 0;
        uns = 0;
        // peek sees the queue as it was before this edge
        m_pv = 0;
        m_pe = 0;
        if (pk) begin
            if (off < sz) begin
                m_pd = WIDTH'(q[off]);
                m_pv = 1;
            end else begin
                m_pe = 1;
            end
        end
        m_dv = 0;
        if (fl) begin
            q.delete();
        end else begin
            ovs = enq && !deq && sz == DEPTH;
            uns = deq && sz == 0;
            if (deq && sz > 0) begin
                m_dout = WIDTH'(q.pop_front());
                m_dv   = 1;
            end
            if (enq && (sz < DEPTH || deq))
                q.push_back(din % (1 << WIDTH));
        end
        m_ov = ovs || (m_ov && !clr);
        m_un = uns || (m_un && !clr);
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count",        32'(count),        32'(sz));
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= DEPTH - 2));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
        chk("data_valid",   32'(data_valid),   32'(m_dv));
        chk("data_out",     32'(data_out),     32'(m_dout));
        chk("peek_valid",   32'(peek_valid),   32'(m_pv));
        chk("peek_err",     32'(peek_err),     32'(m_pe));
        chk("peek_data",    32'(peek_data),    32'(m_pd));
        chk("overflow",     32'(overflow),     32'(m_ov));
        chk("underflow",    32'(underflow),    32'(m_un));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data_out"},     32'(data_out),     0);
        chk({tag, "_data_valid"},   32'(data_valid),   0);
        chk({tag, "_peek_data"},    32'(peek_data),    0);
        chk({tag, "_peek_valid"},   32'(peek_valid),   0);
        chk({tag, "_peek_err"},     32'(peek_err),     0);
        chk({tag, "_full"},         32'(full),         0);
        chk({tag, "_empty"},        32'(empty),        1);
        chk({tag, "_almost_full"},  32'(almost_full),  0);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 1);
        chk({tag, "_count"},        32'(count),        0);
        chk({tag, "_overflow"},     32'(overflow),     0);
        chk({tag, "_underflow"},    32'(underflow),    0);
    endtask

    // one clock: drive, edge, update model, compare #1 after the edge
    task automatic step(input bit enq, input bit deq, input int din = 0,
                        input bit fl = 0, input bit clr = 0,
                        input bit pk = 0, input int off = 0);
        enqueue     = enq;
        dequeue     = deq;
        data_in     = WIDTH'(din);
        flush       = fl;
        clear_flags = clr;
        peek_req    = pk;
        peek_offset = AW'(off);
        @(posedge clock);
        model_update(enq, deq, din, fl, clr, pk, off);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        enqueue = 0; dequeue = 0; data_in = '0; flush = 0;
        clear_flags = 0; peek_req = 0; peek_offset = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;
        check_reset_values("rst_async");
        @(posedge clock); #1;
        check_reset_values("rst_hold");
        reset = 1'b0;
        model_reset();

        // fill 0..15
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, i);
            if (i == 1)  chk("ae_at_2",  32'(almost_empty), 1);
            if (i == 2)  chk("ae_at_3",  32'(almost_empty), 0);
            if (i == 12) chk("af_at_13", 32'(almost_full),  0);
            if (i == 13) chk("af_at_14", 32'(almost_full),  1);
        end
        chk("fill_full",  32'(full),     1);
        chk("fill_count", 32'(count),    16);
        chk("fill_no_ov", 32'(overflow), 0);

        // overflow
        step(1, 0, 999);
        chk("ovf_flag",  32'(overflow), 1);
        chk("ovf_count", 32'(count),    16);

        // drain 0..15
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1);
            chk("drain_data", 32'(data_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);

        // simultaneous at full
        for (int i = 0; i < DEPTH; i++) step(1, 0, i);
        step(1, 1, 500);
        chk("sim_full_count", 32'(count),    16);
        chk("sim_full_dout",  32'(data_out), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1);
        chk("sim_full_500", 32'(data_out), 500);

        // simultaneous at empty
        step(0, 0, 0, 0, 1);
        step(1, 1, 7);
        chk("sim_empty_unf",   32'(underflow),  1);
        chk("sim_empty_dv",    32'(data_valid), 0);
        chk("sim_empty_count", 32'(count),      1);
        step(0, 1);

        // peek
        for (int i = 0; i < 10; i++) step(1, 0, 100 + i);
        step(0, 0, 0, 0, 0, 1, 3);
        chk("peek3_data",  32'(peek_data),  103);
        chk("peek3_valid", 32'(peek_valid), 1);
        step(0, 0, 0, 0, 0, 1, 10);
        chk("peek10_err",  32'(peek_err),   1);
        chk("peek10_hold", 32'(peek_data),  103);
        step(0, 1, 0, 0, 0, 1, 0);
        chk("peek0_data", 32'(peek_data), 100);
        chk("peek0_dout", 32'(data_out),  100);

        // flush at count=5 with enqueue, sticky flags retained
        for (int i = 0; i < 4; i++) step(0, 1);
        chk("pre_flush_count", 32'(count), 5);
        step(1, 0, 77, 1);
        chk("flush_count", 32'(count),     0);
        chk("flush_empty", 32'(empty),     1);
        chk("flush_unf",   32'(underflow), 1);
        step(0, 0, 0, 0, 1);
        chk("clear_unf", 32'(underflow), 0);

        // wrap-around stream
        for (int i = 0; i < 40; i++) begin
            step(1, i >= 8, i);
            chk("wrap_cnt_le9", 32'(count <= 9), 1);
        end
        for (int i = 0; i < 9; i++) step(0, 1);
        chk("wrap_last", 32'(data_out), 39);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            bit e, d, f, c, p;
            e = $urandom_range(0, 99) < 55;
            d = $urandom_range(0, 99) < 50;
            p = $urandom_range(0, 99) < 40;
            c = $urandom_range(0, 99) < 5;
            f = $urandom_range(0, 99) < 3;
            if (f) begin
                e = 0;
                d = 0;
            end
            step(e, d, int'($urandom_range(0, 4095)), f, c, p, int'($urandom_range(0, DEPTH - 1)));
        end

        // mid-stream reset after refilling
        for (int i = 0; i < 6; i++) step(1, 1, 200 + i, 0, 0, 1, 0);
        step(1, 0, 300, 0, 0, 1, 0);
        reset = 1'b1;
        #2;
        check_reset_values("rst_mid");
        model_reset();
        idle_inputs();
        @(posedge clock); #1;
        reset = 1'b0;
        step(1, 0, 42);
        step(0, 1);
        chk("post_rst_data", 32'(data_out), 42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
